pipe_hazard_ctrl: RTL

//  Hazard/stall/flush controller for the 5-stage OTTER pipeline (IF ID EX MEM WB).

---
 rtl/pipe_hazard_ctrl.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
//   Hazard, stall and flush controller for the five-stage OTTER pipeline
//   (IF ID EX MEM WB). It drives the stage-register enables and setnull
//   (NOP insert) lines, the EX-stage operand forwarding selects, the
//   ID-stage write-bypass flags, the data-memory wait freeze with its
//   timeout, and the saturating stall/flush performance counters.
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   id_valid, id_rs1/2, id_use_rs1/2   ID-stage instruction and operand use
//   ex_rs1/2, ex_rd, ex_regwrite, ex_memread, ex_branch_taken   EX stage
//   mem_rd, mem_regwrite          MEM-stage destination
//   wb_rd, wb_regwrite            WB-stage destination
//   dmem_req, dmem_ack            data-memory handshake
//   pc_en, ifid_en, idex_en, exmem_en    stage-register enables
//   ifid_null, idex_null, memwb_null     stage-register NOP insert
//   fwd_a, fwd_b                  00 regfile, 01 EX/MEM, 10 MEM/WB
//   id_byp_a, id_byp_b            ID operand takes WB write data
//   err_timeout                   sticky memory-timeout error
//   stall_cnt, flush_cnt          saturating performance counters
module pipe_hazard_ctrl #(
    parameter int CNT_W       = 16,
    parameter int TIMEOUT_W   = 8,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [4:0]       ex_rs1,
    input  logic [4:0]       ex_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_regwrite,
    input  logic             ex_memread,
    input  logic             ex_branch_taken,
    input  logic [4:0]       mem_rd,
    input  logic             mem_regwrite,
    input  logic [4:0]       wb_rd,
    input  logic             wb_regwrite,
    input  logic             dmem_req,
    input  logic             dmem_ack,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             exmem_en,
    output logic             ifid_null,
    output logic             idex_null,
    output logic             memwb_null,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             id_byp_a,
    output logic             id_byp_b,
    output logic             err_timeout,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {RUN, MEM_WAIT, ERROR} state_t;

    // Last wait_cnt value before the timeout fires.
    localparam logic [TIMEOUT_W-1:0] WAIT_LAST = TIMEOUT_W'(MEM_TIMEOUT - 1);

    state_t               state;
    logic [TIMEOUT_W-1:0] wait_cnt;
    logic                 frozen;
    logic                 flush;
    logic                 load_use;

    // Load-use detection keys on ex_memread alone: every load writes a
    // register, so ex_regwrite adds no information here.
    logic unused_ex_regwrite;
    assign unused_ex_regwrite = ex_regwrite;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

    // MEM result is younger than WB result, so it wins; x0 is never forwarded.
    function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                           input logic [4:0] m_rd, input logic m_we,
                                           input logic [4:0] w_rd, input logic w_we);
        if (m_we && m_rd != 5'd0 && m_rd == rs)
            return 2'b01;
        else if (w_we && w_rd != 5'd0 && w_rd == rs)
            return 2'b10;
        else
            return 2'b00;
    endfunction

    function automatic logic byp_sel(input logic [4:0] rs,
                                     input logic [4:0] w_rd, input logic w_we);
        return w_we && w_rd != 5'd0 && w_rd == rs;
    endfunction

    always_comb begin
        frozen   = (state == ERROR)
                 || (state == RUN && dmem_req && !dmem_ack)
                 || (state == MEM_WAIT && !dmem_ack);
        flush    = !frozen && ex_branch_taken;
        load_use = !frozen && !ex_branch_taken && id_valid && ex_memread && ex_rd != 5'd0
                 && ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));

        pc_en      = 1'b1;
        ifid_en    = 1'b1;
        idex_en    = 1'b1;
        exmem_en   = 1'b1;
        ifid_null  = 1'b0;
        idex_null  = 1'b0;
        memwb_null = 1'b0;

        if (rst) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_en    = 1'b0;
            exmem_en   = 1'b0;
            ifid_null  = 1'b1;
            idex_null  = 1'b1;
            memwb_null = 1'b1;
        end else if (frozen) begin
            // Hold everything up to MEM; bubble into WB so no write repeats.
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_en    = 1'b0;
            exmem_en   = 1'b0;
            memwb_null = 1'b1;
        end else if (flush) begin
            ifid_null  = 1'b1;
            idex_null  = 1'b1;
        end else if (load_use) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_null  = 1'b1;
        end

        fwd_a    = rst ? 2'b00 : fwd_sel(ex_rs1, mem_rd, mem_regwrite, wb_rd, wb_regwrite);
        fwd_b    = rst ? 2'b00 : fwd_sel(ex_rs2, mem_rd, mem_regwrite, wb_rd, wb_regwrite);
        id_byp_a = !rst && byp_sel(id_rs1, wb_rd, wb_regwrite);
        id_byp_b = !rst && byp_sel(id_rs2, wb_rd, wb_regwrite);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= RUN;
            wait_cnt    <= '0;
            err_timeout <= 1'b0;
            stall_cnt   <= '0;
            flush_cnt   <= '0;
        end else begin
            if (!pc_en)
                stall_cnt <= sat_inc(stall_cnt);
            if (flush)
                flush_cnt <= sat_inc(flush_cnt);

            case (state)
                RUN: begin
                    if (dmem_req && !dmem_ack) begin
                        state    <= MEM_WAIT;
                        wait_cnt <= '0;
                    end
                end
                MEM_WAIT: begin
                    if (dmem_ack) begin
                        state <= RUN;
                    end else if (wait_cnt == WAIT_LAST) begin
                        state       <= ERROR;
                        err_timeout <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + TIMEOUT_W'(1);
                    end
                end
                ERROR: begin
                    err_timeout <= 1'b1;
                end
                default: begin
                    state <= RUN;
                end
            endcase
        end
    end

endmodule
